// File: rtl/el2_dec_trigger_hit_ctl.sv
// el2_dec_trigger_hit_ctl
//   Carries the decode-stage i0 trigger match vector down the i0 pipe
//   (D -> X -> R), qualifies it with valid/flush/stall, applies optional
//   pairwise chaining, and produces commit-stage trigger hits, the
//   breakpoint-vs-debug action and sticky mtdata1 hit bits. A small
//   debug-handshake FSM masks re-triggering while a halt is pending and
//   for the first instruction after resume.
//
//   Build option: RV_TRIGGER_CHAIN_EN enables pairwise chaining (0/1, 2/3).
//   Without it, mtdata1_chain is ignored and each trigger stands alone.
//
//   Ports:
//     clk, rst_l               core clock, async active-low reset
//     dec_i0_trigger_match_d   per-trigger match for i0 in D
//     dec_i0_valid_d           i0 valid in D
//     dec_pipe_stall           hold all D/X/R trigger state
//     dec_flush_x              kill instructions in X and R
//     mtdata1_action           per trigger: 1 = debug halt, 0 = breakpoint
//     mtdata1_chain            chain bits (bits 0 and 2 used)
//     mtdata1_hit_clr          CSR write clearing hit bits
//     dbg_halted               core is in debug halt
//     dbg_resume_req           debugger resume pulse
//     trigger_hit_r            effective per-trigger hit at R
//     trigger_hit_brkpt_r      take breakpoint exception at R
//     trigger_hit_dbg_r        request debug halt at R
//     mtdata1_hit              sticky hit bits
//     trigger_suppress         matches masked by the debug FSM
module el2_dec_trigger_hit_ctl #(
   parameter int unsigned NUM_TRIG = 4
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic [NUM_TRIG-1:0] dec_i0_trigger_match_d,
   input  logic                dec_i0_valid_d,
   input  logic                dec_pipe_stall,
   input  logic                dec_flush_x,
   input  logic [NUM_TRIG-1:0] mtdata1_action,
   input  logic [NUM_TRIG-1:0] mtdata1_chain,
   input  logic [NUM_TRIG-1:0] mtdata1_hit_clr,
   input  logic                dbg_halted,
   input  logic                dbg_resume_req,
   output logic [NUM_TRIG-1:0] trigger_hit_r,
   output logic                trigger_hit_brkpt_r,
   output logic                trigger_hit_dbg_r,
   output logic [NUM_TRIG-1:0] mtdata1_hit,
   output logic                trigger_suppress
);

   typedef enum logic [1:0] {
      RUN           = 2'd0,
      HALT_WAIT     = 2'd1,
      HALTED        = 2'd2,
      STEP_SUPPRESS = 2'd3
   } state_e;

   state_e              state_q;
   logic                suppress_q;   // HALT_WAIT, HALTED or STEP_SUPPRESS
   logic                hit_mask_q;   // HALT_WAIT or HALTED

   logic                x_valid_q, r_valid_q;
   logic [NUM_TRIG-1:0] x_match_q, r_match_q;
   logic [NUM_TRIG-1:0] match_d_qual;
   logic [NUM_TRIG-1:0] eff;
   logic [NUM_TRIG-1:0] hit_q, hit_d;
   logic                unused_chain;

   assign match_d_qual = dec_i0_trigger_match_d
                       & {NUM_TRIG{dec_i0_valid_d & ~suppress_q}};

   // Flush beats stall and advance; stall freezes both stages.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         x_valid_q <= 1'b0;
         x_match_q <= '0;
         r_valid_q <= 1'b0;
         r_match_q <= '0;
      end else if (dec_flush_x) begin
         x_valid_q <= 1'b0;
         x_match_q <= '0;
         r_valid_q <= 1'b0;
         r_match_q <= '0;
      end else if (!dec_pipe_stall) begin
         x_valid_q <= dec_i0_valid_d;
         x_match_q <= match_d_qual;
         r_valid_q <= x_valid_q;
         r_match_q <= x_match_q;
      end
   end

`ifdef RV_TRIGGER_CHAIN_EN
   // A chained pair only fires when both members match.
   always_comb begin
      eff = r_match_q;
      if (mtdata1_chain[0]) begin
         eff[0] = r_match_q[0] & r_match_q[1];
         eff[1] = r_match_q[0] & r_match_q[1];
      end
      if (mtdata1_chain[2]) begin
         eff[2] = r_match_q[2] & r_match_q[3];
         eff[3] = r_match_q[2] & r_match_q[3];
      end
   end
   assign unused_chain = mtdata1_chain[1] ^ mtdata1_chain[3];
`else
   assign eff          = r_match_q;
   assign unused_chain = ^mtdata1_chain;
`endif

   assign trigger_hit_r       = eff & {NUM_TRIG{r_valid_q & ~hit_mask_q}};
   assign trigger_hit_dbg_r   = (|(trigger_hit_r & mtdata1_action)) & ~dbg_halted;
   assign trigger_hit_brkpt_r = (|(trigger_hit_r & ~mtdata1_action)) & ~trigger_hit_dbg_r;

   // Set wins over a same-cycle clear.
   assign hit_d = (hit_q & ~mtdata1_hit_clr) | trigger_hit_r;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) hit_q <= '0;
      else        hit_q <= hit_d;
   end

   assign mtdata1_hit = hit_q;

   // Debug handshake FSM; suppress/mask flags are registered alongside the
   // state so they are clean decodes of it.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= RUN;
         suppress_q <= 1'b0;
         hit_mask_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (trigger_hit_dbg_r) begin
                  state_q    <= HALT_WAIT;
                  suppress_q <= 1'b1;
                  hit_mask_q <= 1'b1;
               end
            end
            HALT_WAIT: begin
               if (dbg_halted) state_q <= HALTED;
            end
            HALTED: begin
               if (dbg_resume_req) begin
                  state_q    <= STEP_SUPPRESS;
                  hit_mask_q <= 1'b0;
               end
            end
            STEP_SUPPRESS: begin
               if (dec_i0_valid_d && !dec_pipe_stall) begin
                  state_q    <= RUN;
                  suppress_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= RUN;
               suppress_q <= 1'b0;
               hit_mask_q <= 1'b0;
            end
         endcase
      end
   end

   assign trigger_suppress = suppress_q;

endmodule

// File: doc/el2_dec_trigger_hit_ctl.md
Name: el2_dec_trigger_hit_ctl

Overview:
- Consumes the per-trigger i0 match vector produced in decode (dec_i0_trigger_match_d[3:0]).
- Carries each match down the i0 pipe (D->X->R) alongside the instruction.
- Applies trigger chaining and flush/kill qualification.
- Produces commit-stage trigger hits, the breakpoint-vs-debug action, and sticky mtdata1 hit bits for the TLU.
- Includes a small debug-handshake FSM that masks re-triggering while a debug halt is pending and for the first instruction after resume.

Parameters:
NUM_TRIG, 4, number of triggers (fixed 4; even count required for pairwise chaining)

Ports:
clk  input  1  core clock
rst_l  input  1  asynchronous active-low reset
dec_i0_trigger_match_d  input  4  per-trigger match for the i0 instruction in D
dec_i0_valid_d  input  1  i0 instruction valid in D
dec_pipe_stall  input  1  freeze: hold all D/X/R trigger state
dec_flush_x  input  1  kill instructions currently in X and R
mtdata1_action  input  4  per trigger: 1=enter debug, 0=breakpoint exception
mtdata1_chain  input  4  chain bit; only bits 0 and 2 used (pairs 0/1, 2/3)
mtdata1_hit_clr  input  4  CSR write clearing the corresponding hit bit
dbg_halted  input  1  core is in debug halt
dbg_resume_req  input  1  debugger resume request (one-cycle pulse)
trigger_hit_r  output  4  effective per-trigger hit for the valid instruction in R
trigger_hit_brkpt_r  output  1  take breakpoint exception at R
trigger_hit_dbg_r  output  1  request debug halt at R
mtdata1_hit  output  4  sticky hit bits
trigger_suppress  output  1  high while matches are masked by the FSM

Behaviour:
- Reset: all pipe registers, outputs and mtdata1_hit are 0; FSM is RUN.
- Capture in D:
  - match_q = dec_i0_trigger_match_d & {4{dec_i0_valid_d & ~trigger_suppress}}.
  - valid_q = dec_i0_valid_d.
- Pipe advance: the D->X and X->R registers (match and valid) advance only when ~dec_pipe_stall. While stalled, all stage state holds.
- Flush: dec_flush_x clears the X and R valid/match registers at the next edge. Flush takes priority over advance and over stall.
- Latency: a match in D at cycle N appears on trigger_hit_r at cycle N+2 with no stalls, plus one cycle per stall cycle.
- Chaining at R (when chaining is compiled in): if mtdata1_chain[0], then eff[0]=eff[1]=m[0]&m[1]; otherwise each is independent. Same for chain[2] with pair 2/3. chain[1] and chain[3] are ignored.
- trigger_hit_r = eff & {4{r_valid}}. Combinational from R registers; forced to 0 when FSM is HALT_WAIT or HALTED.
- Actions:
  - trigger_hit_dbg_r = |(trigger_hit_r & mtdata1_action) & ~dbg_halted.
  - trigger_hit_brkpt_r = |(trigger_hit_r & ~mtdata1_action) & ~trigger_hit_dbg_r. Debug wins if both apply.
- Hit bits: mtdata1_hit[i] sets on trigger_hit_r[i] and clears on mtdata1_hit_clr[i]. If set and clear occur in the same cycle, set wins. Bits are registered and visible the cycle after the hit.
- FSM (registered):
  - RUN -> HALT_WAIT on trigger_hit_dbg_r.
  - HALT_WAIT -> HALTED when dbg_halted.
  - HALTED -> STEP_SUPPRESS on dbg_resume_req. A resume in any other state is ignored.
  - STEP_SUPPRESS -> RUN on dec_i0_valid_d & ~dec_pipe_stall; that instruction's matches are masked.
  - dec_flush_x in HALT_WAIT does not leave HALT_WAIT; the halt is already requested.
- trigger_suppress = state is HALT_WAIT, HALTED or STEP_SUPPRESS.

Optional Feature:
- Macro RV_TRIGGER_CHAIN_EN.
- Defined: pairwise chaining as described above.
- Undefined: mtdata1_chain is ignored and eff = m for all four triggers. Port list is unchanged.

Test Plan:
- Single match, no stall: match_d=4'b0001, valid_d=1, action=0 at cycle 0 -> cycle 2: trigger_hit_r=0001, brkpt=1, dbg=0; cycle 3: mtdata1_hit=0001.
- Stall hold: match_d=4'b0100 with dec_pipe_stall high for 3 cycles after capture -> trigger_hit_r=0100 at cycle 5; dbg/brkpt held stable across the stall.
- Flush kill: match_d=4'b0010, dec_flush_x asserted while the instruction is in X -> trigger_hit_r stays 0 and mtdata1_hit stays 0.
- Chaining (RV_TRIGGER_CHAIN_EN, chain[0]=1):
  - match 0001 -> no hit.
  - match 0011 -> trigger_hit_r=0011.
  - chain[0]=0 with match 0001 -> hit 0001.
- Debug handshake: action=1 and match 1000 -> dbg=1 at R; FSM goes to HALT_WAIT and suppress=1. A second match in D produces no hit. dbg_halted=1 -> HALTED; resume pulse -> STEP_SUPPRESS. The next valid D instruction with match 1000 produces no hit, and the FSM returns to RUN.
- Hit bit race: mtdata1_hit=0001 with hit_clr=0001 in the same cycle as trigger_hit_r=0001 -> mtdata1_hit stays 0001. Clear alone -> 0000. Reset mid-operation -> all outputs 0 and FSM RUN.
